// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the Tin-wide MAC array; walks the input-channel chunks of
// every output pixel, issues buffer reads and tracks them through a tagged valid pipe, then
// accumulates the reduced MAC results and emits one partial sum per output pixel.
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start_i               start pulse, sampled only in IDLE
//   cfg_tin_iter_i        chunks per output pixel, latched on an accepted start
//   cfg_pix_i             output pixels per job, latched on an accepted start
//   stall_i               freezes issue; in-flight data still drains
//   busy_o, done_o        job active / one-cycle end-of-job pulse
//   buf_rd_en_o           one read strobe per issued chunk
//   buf_rd_addr_o         linear feature address pix*tin_iter + ch
//   wt_rd_addr_o          weight chunk index ch
//   mac_dat_i             reduced MAC output, sampled on tagged cycles
//   out_vld_o             one-cycle pulse qualifying out_dat_o / out_idx_o
//   out_dat_o, out_idx_o  accumulated pixel sum and its pixel index
module mac_seq_ctrl #(
  parameter int DW_IN   = 20,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = 20,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  cfg_tin_iter_i,
  input  logic [CNT_W-1:0]  cfg_pix_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              buf_rd_en_o,
  output logic [ADDR_W-1:0] buf_rd_addr_o,
  output logic [CNT_W-1:0]  wt_rd_addr_o,
  input  logic [DW_IN-1:0]  mac_dat_i,
  output logic              out_vld_o,
  output logic [ACC_W-1:0]  out_dat_o,
  output logic [CNT_W-1:0]  out_idx_o
);
  localparam int P = RD_LAT + MAC_LAT;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] tin_q, npix_q, ch_q, pix_q, out_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [P-1:0] vld_q, first_q, last_q;
  logic [P-1:0][CNT_W-1:0] tpix_q;
  logic [ACC_W-1:0] acc_q, acc_d, ext, out_dat_q;
  logic out_vld_q, issue, ch_last, pix_last, accept;
  assign accept   = state_q == IDLE && start_i && |cfg_tin_iter_i && |cfg_pix_i;
  assign issue    = state_q == RUN && !stall_i;
  assign ch_last  = ch_q == tin_q - CNT_W'(1);
  assign pix_last = pix_q == npix_q - CNT_W'(1);
  assign ext      = {{(ACC_W-DW_IN){mac_dat_i[DW_IN-1]}}, mac_dat_i};
  // the first chunk of a pixel reloads instead of adding, so no explicit clear is needed
  assign acc_d    = first_q[P-1] ? ext : acc_q + ext;
  assign buf_rd_addr_o = addr_q;
  assign wt_rd_addr_o  = ch_q;
  assign out_vld_o     = out_vld_q;
  assign out_dat_o     = out_dat_q;
  assign out_idx_o     = out_idx_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = accept ? RUN : DONE;
      RUN:   if (issue && ch_last && pix_last) state_d = DRAIN;
      DRAIN: if (~|vld_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_o      = state_q == RUN || state_q == DRAIN;
    done_o      = state_q == DONE;
    buf_rd_en_o = issue;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tin_q  <= '0;
      npix_q <= '0;
      ch_q   <= '0;
      pix_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      tin_q  <= cfg_tin_iter_i;
      npix_q <= cfg_pix_i;
      ch_q   <= '0;
      pix_q  <= '0;
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= addr_q + ADDR_W'(1);
      ch_q   <= ch_last ? '0 : ch_q + CNT_W'(1);
      pix_q  <= pix_q + CNT_W'(ch_last);
    end
  // tag pipe mirrors the read + MAC latency; a bubble is simply a cleared vld bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      tpix_q  <= '0;
    end else begin
      vld_q   <= {vld_q[P-2:0], issue};
      first_q <= {first_q[P-2:0], ch_q == '0};
      last_q  <= {last_q[P-2:0], ch_last};
      tpix_q  <= {tpix_q[P-2:0], pix_q};
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q     <= '0;
      out_dat_q <= '0;
      out_idx_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (vld_q[P-1]) acc_q <= acc_d;
      if (vld_q[P-1] && last_q[P-1]) begin
        out_dat_q <= acc_d;
        out_idx_q <= tpix_q[P-1];
      end
      out_vld_q <= vld_q[P-1] && last_q[P-1];
    end
endmodule
